// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier feeder: operand/product widths,
// tag width, sequencer state encoding and small helpers.
package mult_pkg;

  localparam int OPW  = 4;
  localparam int PW   = 8;
  localparam int TAGW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Issue sequence number advance; wraps naturally at 2**TAGW.
  function automatic logic [TAGW-1:0] tag_inc(input logic [TAGW-1:0] tag);
    return tag + TAGW'(1);
  endfunction

  // Operand pair as stored in the FIFO: a in the upper half, b in the lower.
  function automatic logic [2*OPW-1:0] pack_ops(input logic [OPW-1:0] a,
                                                input logic [OPW-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO holding packed operand pairs. The head entry is
// visible on dout whenever the FIFO is not empty; no bypass from din.
module mult_op_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 8
) (
  input  logic          ck,
  input  logic          res,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (cnt_r == (AW+1)'(DEPTH));
  assign empty     = (cnt_r == {(AW+1){1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = cnt_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge ck) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap modulo DEPTH; occupancy holds on simultaneous push and pop.
  always_ff @(posedge ck) begin
    if (res) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/mult_feeder.sv
// Sequencer in front of the 4x4 shift-add multiplier: buffers operand pairs,
// issues one at a time, captures the product on done and presents it with
// its issue tag. A result must be consumed before the next pair is issued,
// so capture never has to stall.
module mult_feeder
  import mult_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 8
) (
  input  logic            ck,
  input  logic            res,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_a,
  input  logic [OPW-1:0]  in_b,
  output logic            m_start,
  output logic [OPW-1:0]  m_a,
  output logic [OPW-1:0]  m_b,
  input  logic            m_done,
  input  logic [PW-1:0]   m_p,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_p,
  output logic [TAGW-1:0] out_tag,
  output logic [AW:0]     fifo_cnt,
  output logic            timeout_err
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t              state_r;
  state_t              state_nxt_s;

  logic                fifo_push_s;
  logic                fifo_pop_s;
  logic [2*OPW-1:0]    fifo_head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;

  logic                m_start_r,     m_start_nxt_s;
  logic [OPW-1:0]      m_a_r,         m_a_nxt_s;
  logic [OPW-1:0]      m_b_r,         m_b_nxt_s;
  logic                out_valid_r,   out_valid_nxt_s;
  logic [PW-1:0]       out_p_r,       out_p_nxt_s;
  logic [TAGW-1:0]     out_tag_r,     out_tag_nxt_s;
  logic                timeout_err_r, timeout_err_nxt_s;
  logic [WCW-1:0]      wait_cnt_r,    wait_cnt_nxt_s;
  logic [TAGW-1:0]     tag_cnt_r,     tag_cnt_nxt_s;
  logic [TAGW-1:0]     tag_lat_r,     tag_lat_nxt_s;
  logic                wait_expired_s;

  assign in_ready       = ~fifo_full_s;
  assign fifo_push_s    = in_valid & in_ready;
  assign wait_expired_s = (wait_cnt_r == WCW'(TIMEOUT - 1));

  assign m_start     = m_start_r;
  assign m_a         = m_a_r;
  assign m_b         = m_b_r;
  assign out_valid   = out_valid_r;
  assign out_p       = out_p_r;
  assign out_tag     = out_tag_r;
  assign timeout_err = timeout_err_r;

  mult_op_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (2*OPW)
  ) u_fifo (
    .ck    (ck),
    .res   (res),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (pack_ops(in_a, in_b)),
    .dout  (fifo_head_s),
    .count (fifo_cnt),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // State register.
  always_ff @(posedge ck) begin
    if (res) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: issue only into an empty result slot; leave WAIT on done or expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s && !out_valid_r) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (m_done || wait_expired_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output/datapath next values; start and operands are loaded on entry to ISSUE
  // so they are already registered during the ISSUE cycle.
  always_comb begin
    m_start_nxt_s     = 1'b0;
    m_a_nxt_s         = m_a_r;
    m_b_nxt_s         = m_b_r;
    fifo_pop_s        = 1'b0;
    tag_cnt_nxt_s     = tag_cnt_r;
    tag_lat_nxt_s     = tag_lat_r;
    wait_cnt_nxt_s    = wait_cnt_r;
    out_valid_nxt_s   = out_valid_r & ~out_ready;
    out_p_nxt_s       = out_p_r;
    out_tag_nxt_s     = out_tag_r;
    timeout_err_nxt_s = timeout_err_r;
    case (state_r)
      IDLE: begin
        if (state_nxt_s == ISSUE) begin
          m_start_nxt_s = 1'b1;
          m_a_nxt_s     = fifo_head_s[2*OPW-1:OPW];
          m_b_nxt_s     = fifo_head_s[OPW-1:0];
        end else begin
          m_start_nxt_s = 1'b0;
        end
      end
      ISSUE: begin
        fifo_pop_s     = 1'b1;
        tag_lat_nxt_s  = tag_cnt_r;
        tag_cnt_nxt_s  = tag_inc(tag_cnt_r);
        wait_cnt_nxt_s = {WCW{1'b0}};
      end
      WAIT: begin
        if (m_done) begin
          out_valid_nxt_s = 1'b1;
          out_p_nxt_s     = m_p;
          out_tag_nxt_s   = tag_lat_r;
        end else if (wait_expired_s) begin
          timeout_err_nxt_s = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WCW'(1);
        end
      end
      default: begin
        m_start_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any in-flight operation.
  always_ff @(posedge ck) begin
    if (res) begin
      m_start_r     <= 1'b0;
      m_a_r         <= {OPW{1'b0}};
      m_b_r         <= {OPW{1'b0}};
      out_valid_r   <= 1'b0;
      out_p_r       <= {PW{1'b0}};
      out_tag_r     <= {TAGW{1'b0}};
      timeout_err_r <= 1'b0;
      wait_cnt_r    <= {WCW{1'b0}};
      tag_cnt_r     <= {TAGW{1'b0}};
      tag_lat_r     <= {TAGW{1'b0}};
    end else begin
      m_start_r     <= m_start_nxt_s;
      m_a_r         <= m_a_nxt_s;
      m_b_r         <= m_b_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      out_p_r       <= out_p_nxt_s;
      out_tag_r     <= out_tag_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      tag_cnt_r     <= tag_cnt_nxt_s;
      tag_lat_r     <= tag_lat_nxt_s;
    end
  end

endmodule

// File: tb/tb_mult_feeder.sv
// Directed bench for mult_feeder with a behavioural multiplier model and a
// result scoreboard checked by an independent monitor.
module tb_mult_feeder;

  logic       ck;
  logic       res;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       m_start;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic       m_done;
  logic [7:0] m_p;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic [1:0] out_tag;
  logic [2:0] fifo_cnt;
  logic       timeout_err;

  logic       mdl_done_s;
  logic       frc_done_s;
  logic       mdl_never_s;
  logic [1:0] tag_mdl;

  int checks;
  int errors;

  typedef struct packed {
    logic [7:0] p;
    logic [1:0] tag;
  } exp_t;

  exp_t sb[$];

  assign m_done = mdl_done_s | frc_done_s;

  mult_feeder dut (
    .ck          (ck),
    .res         (res),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .m_start     (m_start),
    .m_a         (m_a),
    .m_b         (m_b),
    .m_done      (m_done),
    .m_p         (m_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_p       (out_p),
    .out_tag     (out_tag),
    .fifo_cnt    (fifo_cnt),
    .timeout_err (timeout_err)
  );

  // Clock.
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Multiplier model: done is high in the 5th cycle after the start cycle.
  initial begin
    logic [7:0] pa;
    logic [7:0] pb;
    mdl_done_s = 1'b0;
    m_p        = 8'h00;
    forever begin
      @(negedge ck);
      if (m_start && !mdl_never_s) begin
        pa = {4'h0, m_a};
        pb = {4'h0, m_b};
        repeat (5) @(posedge ck);
        #1;
        mdl_done_s = 1'b1;
        m_p        = pa * pb;
        @(posedge ck);
        #1;
        mdl_done_s = 1'b0;
        m_p        = 8'h00;
      end
    end
  end

  // Result monitor: pops the scoreboard on every accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge ck);
      #2;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result actual p=%02h tag=%0d required=no result", out_p, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_p !== e.p || out_tag !== e.tag) begin
            errors++;
            $display("FAIL result actual p=%02h tag=%0d required p=%02h tag=%0d",
                     out_p, out_tag, e.p, e.tag);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp_p, input bit expect_res);
    int   n;
    exp_t e;
    n = 0;
    @(negedge ck);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge ck);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_accept actual=in_ready 0 required=in_ready 1");
    end else begin
      e.p   = exp_p;
      e.tag = tag_mdl;
      if (expect_res) begin
        sb.push_back(e);
      end
      tag_mdl = tag_mdl + 2'd1;
    end
    @(posedge ck);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge ck);
      n++;
    end
    repeat (3) @(negedge ck);
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge ck);
    res = 1'b1;
    repeat (2) @(negedge ck);
    res     = 1'b0;
    tag_mdl = 2'd0;
  endtask

  // Directed stimulus.
  initial begin
    int st;
    int n;
    int bad;
    res         = 1'b1;
    in_valid    = 1'b0;
    in_a        = 4'h0;
    in_b        = 4'h0;
    out_ready   = 1'b1;
    frc_done_s  = 1'b0;
    mdl_never_s = 1'b0;
    tag_mdl     = 2'd0;
    checks      = 0;
    errors      = 0;

    // Reset state.
    repeat (3) @(negedge ck);
    res = 1'b0;
    @(negedge ck);
    chk("rst_m_start",   32'(m_start),     32'd0);
    chk("rst_m_a",       32'(m_a),         32'd0);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_out_p",     32'(out_p),       32'd0);
    chk("rst_fifo_cnt",  32'(fifo_cnt),    32'd0);
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_timeout",   32'(timeout_err), 32'd0);

    // Stale done with an empty FIFO is ignored.
    frc_done_s = 1'b1;
    repeat (3) begin
      @(negedge ck);
      chk("stale_m_start",   32'(m_start),   32'd0);
      chk("stale_out_valid", 32'(out_valid), 32'd0);
    end
    frc_done_s = 1'b0;
    repeat (2) @(negedge ck);

    // Single pair 15x15 with exact result latency.
    push_pair(4'hF, 4'hF, 8'hE1, 1'b1);
    repeat (6) @(posedge ck);
    #1;
    chk("lat_t7_out_valid", 32'(out_valid), 32'd0);
    @(posedge ck);
    #1;
    chk("lat_t8_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Five pairs back-to-back; FIFO fills to 4 and tags run 0,1,2,3,0.
    do_reset();
    push_pair(4'h1, 4'h2, 8'h02, 1'b1);
    push_pair(4'h3, 4'h4, 8'h0C, 1'b1);
    push_pair(4'h5, 4'h6, 8'h1E, 1'b1);
    push_pair(4'h7, 4'h8, 8'h38, 1'b1);
    push_pair(4'h9, 4'hA, 8'h5A, 1'b1);
    chk("full_fifo_cnt", 32'(fifo_cnt), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Consumer stall: only one issue until the result is taken.
    @(negedge ck);
    out_ready = 1'b0;
    push_pair(4'h2, 4'h3, 8'h06, 1'b1);
    push_pair(4'h4, 4'h4, 8'h10, 1'b1);
    st = 0;
    repeat (30) begin
      @(negedge ck);
      if (m_start) st++;
    end
    chk("stall_issues",    32'(st),        32'd1);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_fifo_cnt",  32'(fifo_cnt),  32'd1);
    out_ready = 1'b1;
    st = 0;
    repeat (2) begin
      @(negedge ck);
      if (m_start) st++;
    end
    chk("stall_reissue", 32'(st), 32'd1);
    drain();

    // Multiplier never answers: abort after 8 WAIT cycles, then recover.
    mdl_never_s = 1'b1;
    push_pair(4'h6, 4'h7, 8'h00, 1'b0);
    n = 0;
    while (!m_start && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("to_issue", 32'(m_start), 32'd1);
    repeat (8) @(negedge ck);
    chk("to_before", 32'(timeout_err), 32'd0);
    @(negedge ck);
    chk("to_after", 32'(timeout_err), 32'd1);
    mdl_never_s = 1'b0;
    push_pair(4'h3, 4'h5, 8'h0F, 1'b1);
    drain();
    chk("to_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT flushes everything; the late done is ignored.
    push_pair(4'h2, 4'h2, 8'h00, 1'b0);
    push_pair(4'h3, 4'h3, 8'h00, 1'b0);
    n = 0;
    while (!m_start && n < 40) begin
      @(negedge ck);
      n++;
    end
    chk("wr_issue", 32'(m_start), 32'd1);
    repeat (2) @(negedge ck);
    res = 1'b1;
    @(negedge ck);
    chk("wr_m_start",   32'(m_start),     32'd0);
    chk("wr_m_a",       32'(m_a),         32'd0);
    chk("wr_m_b",       32'(m_b),         32'd0);
    chk("wr_out_valid", 32'(out_valid),   32'd0);
    chk("wr_out_p",     32'(out_p),       32'd0);
    chk("wr_out_tag",   32'(out_tag),     32'd0);
    chk("wr_timeout",   32'(timeout_err), 32'd0);
    chk("wr_fifo_cnt",  32'(fifo_cnt),    32'd0);
    chk("wr_in_ready",  32'(in_ready),    32'd1);
    res     = 1'b0;
    tag_mdl = 2'd0;
    bad = 0;
    repeat (10) begin
      @(negedge ck);
      if (m_start || out_valid) bad++;
    end
    chk("wr_late_done", 32'(bad), 32'd0);

    // Normal operation after reset restarts tags at 0.
    push_pair(4'h1, 4'h1, 8'h01, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
